// File: rtl/store_buffer.sv
// store_buffer: write-back store FIFO between EX and data memory; loads own the dm port.
// Define STORE_BUFFER_FWD_EN to forward load hits from the buffer instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              result,
  input  logic [DW-1:0]              WriteData,
  input  logic                       MemWrite,
  input  logic                       MemRead,
  output logic [DW-1:0]              ReadData,
  output logic                       stall,
  output logic [AW-1:0]              dm_addr,
  output logic [DW-1:0]              dm_wdata,
  output logic                       dm_we,
  output logic                       dm_re,
  input  logic [DW-1:0]              dm_rdata,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count;
  logic w_load, w_hit, w_miss, w_drain;
  logic [PW-1:0] w_idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [DW-1:0] w_fdata;
`endif
  // Valid entries are contiguous from head, so the last match scanned is the youngest.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    w_fdata = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (r_valid[w_idx] && r_addr[w_idx] == result) begin
        w_hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        w_fdata = r_data[w_idx];
`endif
      end
    end
  end
  assign w_load  = MemRead & ~MemWrite;
  assign w_miss  = w_load & ~w_hit;
  assign w_drain = (r_count != '0) & (~w_load | w_hit);
  assign dm_we    = w_drain;
  assign dm_re    = w_miss;
  assign dm_addr  = w_drain ? r_addr[r_head] : w_miss ? result : '0;
  assign dm_wdata = w_drain ? r_data[r_head] : '0;
  assign occupancy = r_count;
`ifdef STORE_BUFFER_FWD_EN
  assign stall    = 1'b0;
  assign ReadData = w_load ? (w_hit ? w_fdata : dm_rdata) : '0;
`else
  assign stall    = w_load & w_hit;
  assign ReadData = w_miss ? dm_rdata : '0;
`endif
  // Enqueue follows drain so a full-buffer store reuses the slot just retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (MemWrite) begin
        r_addr[r_tail]  <= result;
        r_data[r_tail]  <= WriteData;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      r_count <= r_count + (PW+1)'(MemWrite) - (PW+1)'(w_drain);
    end
  end
endmodule
